// File: rtl/uart_boot_writer_if.sv
// Boot-memory write port: one-cycle strobe with word address and data.
// The loader drives the master side; boot memory (or a bench) takes the slave side.
interface uart_boot_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output wr_en, addr, wr_data);
  modport slave  (input  wr_en, addr, wr_data);
endinterface

// File: rtl/uart_boot_writer.sv
// Serial boot loader: 8N1 UART bytes packed big-endian into words and written
// to consecutive boot-memory addresses until WORD_COUNT words have landed.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing to mid start bit; high there means a glitch
// S_DATA  | sampling 8 data bits LSB first, one per BAUD_DIV cycles
// S_STOP  | sampling the stop bit; accept byte or flag framing error
// S_BREAK | framing error seen, waiting for the line to return high
module uart_boot_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int BAUD_DIV   = 434,
  parameter int WORD_COUNT = 'h120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_rx,
  uart_boot_writer_if.master boot_mem,
  output logic               load_done,
  output logic               frame_err
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int TMR_W  = $clog2(BAUD_DIV);
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int ACC_W  = (BYTES > 1) ? DATA_WIDTH - 8 : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                state_q,     state_d;
  logic                  rx_meta_q,   rx_meta_d;
  logic                  rx_s_q,      rx_s_d;
  logic [TMR_W-1:0]      tmr_q,       tmr_d;
  logic [2:0]            bit_idx_q,   bit_idx_d;
  logic [7:0]            shift_q,     shift_d;
  logic [BIDX_W-1:0]     byte_idx_q,  byte_idx_d;
  logic [ACC_W-1:0]      acc_q,       acc_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q,  word_cnt_d;
  logic                  wr_en_q,     wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
  logic                  load_done_q, load_done_d;
  logic                  frame_err_q, frame_err_d;

  logic                  tmr_tc;
  logic [DATA_WIDTH-1:0] next_word;

  assign tmr_tc = (tmr_q == '0);

  // acc_q holds the earlier bytes of the word; the byte just received goes at the LSB end.
  generate
    if (BYTES > 1) begin : g_multi_byte
      assign next_word = {acc_q, shift_q};
    end else begin : g_single_byte
      assign next_word = shift_q;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = uart_rx;
    rx_s_d      = rx_meta_q;
    tmr_d       = tmr_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    acc_d       = acc_q;
    word_cnt_d  = word_cnt_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = frame_err_q;
    load_done_d = load_done_q | (word_cnt_q == ADDR_WIDTH'(WORD_COUNT));

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tmr_d   = TMR_W'(BAUD_DIV / 2 - 1);
        end
      end
      S_START: begin
        if (!tmr_tc) begin
          tmr_d = tmr_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_DATA;
          tmr_d     = TMR_W'(BAUD_DIV - 1);
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (!tmr_tc) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          tmr_d     = TMR_W'(BAUD_DIV - 1);
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!tmr_tc) begin
          tmr_d = tmr_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = S_IDLE;
          if (!load_done_q) begin
            acc_d = next_word[ACC_W-1:0];
            if (byte_idx_q == BIDX_W'(BYTES - 1)) begin
              byte_idx_d = '0;
              wr_en_d    = 1'b1;
              addr_d     = word_cnt_q;
              wr_data_d  = next_word;
              word_cnt_d = word_cnt_q + 1'b1;
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end
        end else begin
          // A bad stop bit loses word alignment, so the partial word is dropped.
          frame_err_d = 1'b1;
          byte_idx_d  = '0;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tmr_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      acc_q       <= '0;
      word_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      tmr_q       <= tmr_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      acc_q       <= acc_d;
      word_cnt_q  <= word_cnt_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign boot_mem.wr_en   = wr_en_q;
  assign boot_mem.addr    = addr_q;
  assign boot_mem.wr_data = wr_data_q;
  assign load_done        = load_done_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_uart_boot_writer.sv
// Bench for uart_boot_writer: serial byte driver, byte-list reference model of
// the expected boot-memory writes, and one task per scenario.
module tb_uart_boot_writer;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int BD = 8;
  localparam int WC = 2;
  localparam int BYTES = DW / 8;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic uart_rx = 1'b1;
  logic load_done, frame_err;

  always #5 clk = ~clk;

  uart_boot_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bm ();

  uart_boot_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BAUD_DIV(BD), .WORD_COUNT(WC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .boot_mem(bm), .load_done(load_done), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed writes, captured mid-cycle; cleared while reset is asserted.
  logic [AW-1:0] cap_addr[$];
  logic [DW-1:0] cap_data[$];
  int            cap_cyc[$];
  int            done_cyc = -1;

  // Reference model state.
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [7:0]    pend[$];
  int            m_cnt;
  bit            m_ferr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap_addr.delete();
      cap_data.delete();
      cap_cyc.delete();
      done_cyc <= -1;
    end else begin
      if (bm.wr_en) begin
        cap_addr.push_back(bm.addr);
        cap_data.push_back(bm.wr_data);
        cap_cyc.push_back(cyc);
      end
      if (load_done && done_cyc < 0) done_cyc <= cyc;
    end
  end

  function automatic void model_reset();
    exp_addr.delete();
    exp_data.delete();
    pend.delete();
    m_cnt  = 0;
    m_ferr = 1'b0;
  endfunction

  // Whole bytes only: a word is BYTES good bytes in a row, first byte most significant.
  function automatic void model_byte(logic [7:0] b, bit ok);
    logic [DW-1:0] w;
    if (!ok) begin
      m_ferr = 1'b1;
      pend.delete();
      return;
    end
    if (m_cnt >= WC) return;
    pend.push_back(b);
    if (pend.size() == BYTES) begin
      w = '0;
      foreach (pend[i]) w = w * 256 + DW'(pend[i]);
      exp_addr.push_back(AW'(m_cnt));
      exp_data.push_back(w);
      m_cnt++;
      pend.delete();
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    if (bad_stop) begin
      uart_rx = 1'b0;
      repeat (2 * BD) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BD) @(negedge clk);
    model_byte(b, !bad_stop);
  endtask

  task automatic apply_reset();
    uart_rx = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bit saw_wr, saw_addr, saw_data, saw_done, saw_ferr;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bm.wr_en, bm.addr, bm.wr_data, load_done, frame_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got wr_en=%b addr=%h data=%h done=%b ferr=%b, required all 0",
               bm.wr_en, bm.addr, bm.wr_data, load_done, frame_err);
    end
    apply_reset();
    {saw_wr, saw_addr, saw_data, saw_done, saw_ferr} = '0;
    repeat (1000) begin
      @(negedge clk);
      saw_wr   |= bm.wr_en;
      saw_addr |= (bm.addr != '0);
      saw_data |= (bm.wr_data != '0);
      saw_done |= load_done;
      saw_ferr |= frame_err;
    end
    n_checks++;
    if (saw_wr !== 1'b0) begin n_fail++; $display("FAIL idle_wr_en: got strobe=%b, required 0", saw_wr); end
    n_checks++;
    if (saw_addr !== 1'b0 || saw_data !== 1'b0) begin
      n_fail++; $display("FAIL idle_addr_data: got nonzero addr=%b data=%b, required 0", saw_addr, saw_data);
    end
    n_checks++;
    if (saw_done !== 1'b0 || saw_ferr !== 1'b0) begin
      n_fail++; $display("FAIL idle_flags: got done=%b ferr=%b, required 0", saw_done, saw_ferr);
    end
  endtask

  task automatic test_single_word();
    int t_last;
    apply_reset();
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    t_last = cyc;
    send_byte(8'hEF);
    repeat (20) @(negedge clk);
    n_checks++;
    if (cap_addr.size() !== 1) begin
      n_fail++; $display("FAIL single_word_count: got %0d writes, required 1", cap_addr.size());
    end
    if (cap_addr.size() > 0) begin
      n_checks++;
      if (cap_addr[0] !== 20'h0 || cap_data[0] !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL single_word_data: got (%h,%h), required (0,deadbeef)", cap_addr[0], cap_data[0]);
      end
      // sync 2 + idle detect 1 + half-bit start timer + 9 bit times to the stop sample
      n_checks++;
      if (cap_cyc[0] - t_last !== 3 + BD / 2 + 9 * BD) begin
        n_fail++; $display("FAIL single_word_latency: got %0d cycles, required %0d", cap_cyc[0] - t_last, 3 + BD / 2 + 9 * BD);
      end
    end
    n_checks++;
    if (bm.addr !== 20'h0 || bm.wr_data !== 32'hDEADBEEF || bm.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL single_word_hold: got addr=%h data=%h wr_en=%b, required 0/deadbeef/0", bm.addr, bm.wr_data, bm.wr_en);
    end
    n_checks++;
    if (load_done !== 1'b0) begin n_fail++; $display("FAIL single_word_done: got %b, required 0", load_done); end
  endtask

  task automatic test_full_image();
    apply_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    repeat (20) @(negedge clk);
    n_checks++;
    if (cap_addr.size() !== 2) begin
      n_fail++; $display("FAIL full_count: got %0d writes, required 2", cap_addr.size());
    end else begin
      n_checks++;
      if (cap_addr[0] !== 20'h0 || cap_data[0] !== 32'h01020304 ||
          cap_addr[1] !== 20'h1 || cap_data[1] !== 32'h05060708) begin
        n_fail++; $display("FAIL full_data: got (%h,%h) (%h,%h), required (0,01020304) (1,05060708)",
                           cap_addr[0], cap_data[0], cap_addr[1], cap_data[1]);
      end
      n_checks++;
      if (done_cyc !== cap_cyc[1] + 1) begin
        n_fail++; $display("FAIL full_done_timing: got load_done at %0d, required %0d", done_cyc, cap_cyc[1] + 1);
      end
    end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
    repeat (20) @(negedge clk);
    n_checks++;
    if (cap_addr.size() !== exp_addr.size() || load_done !== 1'b1) begin
      n_fail++; $display("FAIL full_frozen: got %0d writes done=%b, required %0d writes done=1",
                         cap_addr.size(), load_done, exp_addr.size());
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    apply_reset();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (cap_addr.size() !== 0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL glitch_ignored: got %0d writes ferr=%b, required 0 writes ferr=0", cap_addr.size(), frame_err);
    end
    for (int i = 0; i < BYTES; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (cap_addr.size() !== 1 || exp_addr.size() !== 1) begin
      n_fail++; $display("FAIL glitch_word_count: got %0d writes, required 1", cap_addr.size());
    end else if (cap_addr[0] !== exp_addr[0] || cap_data[0] !== exp_data[0]) begin
      n_fail++; $display("FAIL glitch_word: got (%h,%h), required (%h,%h)", cap_addr[0], cap_data[0], exp_addr[0], exp_data[0]);
    end
  endtask

  task automatic test_frame_err();
    apply_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b, required 1", frame_err); end
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (20) @(negedge clk);
    n_checks++;
    if (cap_addr.size() !== 1) begin
      n_fail++; $display("FAIL ferr_count: got %0d writes, required 1", cap_addr.size());
    end else if (cap_addr[0] !== 20'h0 || cap_data[0] !== 32'h11223344) begin
      n_fail++; $display("FAIL ferr_word: got (%h,%h), required (0,11223344)", cap_addr[0], cap_data[0]);
    end
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b, required 1", frame_err); end
  endtask

  task automatic test_reset_mid_word();
    apply_reset();
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'($urandom_range(0, 1));
      repeat (BD) @(negedge clk);
    end
    apply_reset();
    repeat (20) @(negedge clk);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hBA);
    send_byte(8'hBE);
    repeat (20) @(negedge clk);
    n_checks++;
    if (cap_addr.size() !== 1) begin
      n_fail++; $display("FAIL rstmid_count: got %0d writes, required 1", cap_addr.size());
    end else if (cap_addr[0] !== 20'h0 || cap_data[0] !== 32'hCAFEBABE) begin
      n_fail++; $display("FAIL rstmid_word: got (%h,%h), required (0,cafebabe)", cap_addr[0], cap_data[0]);
    end
    n_checks++;
    if (frame_err !== 1'b0 || load_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags: got ferr=%b done=%b, required 0/0", frame_err, load_done);
    end
  endtask

  task automatic test_random();
    int nbytes;
    bit bad;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      nbytes = $urandom_range(4, 13);
      for (int i = 0; i < nbytes; i++) begin
        bad = ($urandom_range(0, 7) == 0);
        send_byte(8'($urandom_range(0, 255)), bad);
        repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      repeat (30) @(negedge clk);
      n_checks++;
      if (cap_addr.size() !== exp_addr.size()) begin
        n_fail++; $display("FAIL random_count it=%0d: got %0d writes, required %0d", it, cap_addr.size(), exp_addr.size());
      end else begin
        foreach (exp_addr[i]) begin
          n_checks++;
          if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL random_word it=%0d #%0d: got (%h,%h), required (%h,%h)",
                               it, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      n_checks++;
      if (load_done !== (m_cnt == WC) || frame_err !== m_ferr) begin
        n_fail++; $display("FAIL random_flags it=%0d: got done=%b ferr=%b, required done=%b ferr=%b",
                           it, load_done, frame_err, (m_cnt == WC), m_ferr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_image();
    test_glitch();
    test_frame_err();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
